// File: rtl/dual_pe_mem_sequencer.sv
// dual_pe_mem_sequencer
// Serialises the PE1/PE2 memory-stage accesses onto one shared data-memory
// port, PE1 (older) first, and holds both lanes with StallM until every
// access in the bundle has completed.
// Optional build macro: MEM_ST_LD_FWD_EN (PE1 store -> PE2 load same-word
// forwarding, which skips the PE2 memory access).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | inspect bundle; launch PE1 (or PE2) access if one is needed
// ACC1  | PE1 access outstanding on the memory port
// ACC2  | PE2 access outstanding on the memory port
// DONE  | all accesses complete; stall released, bundle advances
module dual_pe_mem_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWriteM1,
  input  logic              MemWriteM2,
  input  logic              ResultSrcM1,
  input  logic              ResultSrcM2,
  input  logic [ADDR_W-1:0] ALU_ResultM1,
  input  logic [ADDR_W-1:0] ALU_ResultM2,
  input  logic [DATA_W-1:0] WriteDataM1,
  input  logic [DATA_W-1:0] WriteDataM2,
  output logic              StallM,
  output logic [DATA_W-1:0] ReadDataM1,
  output logic [DATA_W-1:0] ReadDataM2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC1 = 2'd1;
  localparam logic [1:0] ACC2 = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state;
  logic       need1;
  logic       need2;
  logic       isLoad1;
  logic       isLoad2;
  logic       fwdHit;

  // A lane with both store and load set is treated as a store.
  assign need1   = MemWriteM1 | ResultSrcM1;
  assign need2   = MemWriteM2 | ResultSrcM2;
  assign isLoad1 = ResultSrcM1 & ~MemWriteM1;
  assign isLoad2 = ResultSrcM2 & ~MemWriteM2;

`ifdef MEM_ST_LD_FWD_EN
  // PE2 load of the word PE1 is storing: take the data straight from PE1.
  assign fwdHit = MemWriteM1 & isLoad2 &
                  (ALU_ResultM1[ADDR_W-1:2] == ALU_ResultM2[ADDR_W-1:2]);
`else
  assign fwdHit = 1'b0;
`endif

  // Stall while a bundle needing memory sits in IDLE or an access is open.
  assign StallM = ((state == IDLE) & (need1 | need2)) |
                  (state == ACC1) | (state == ACC2);

  // Sequencer FSM with registered memory-port outputs and load capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ReadDataM1 <= '0;
      ReadDataM2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (need1) begin
            state     <= ACC1;
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM1;
            mem_addr  <= ALU_ResultM1;
            mem_wdata <= WriteDataM1;
          end else if (need2) begin
            state     <= ACC2;
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM2;
            mem_addr  <= ALU_ResultM2;
            mem_wdata <= WriteDataM2;
          end
        end
        ACC1: begin
          if (mem_ready) begin
            if (isLoad1) begin
              ReadDataM1 <= mem_rdata;
            end
            if (fwdHit) begin
              ReadDataM2 <= WriteDataM1;
              state      <= DONE;
              mem_req    <= 1'b0;
            end else if (need2) begin
              // Back-to-back: mem_req stays high into the PE2 access.
              state     <= ACC2;
              mem_we    <= MemWriteM2;
              mem_addr  <= ALU_ResultM2;
              mem_wdata <= WriteDataM2;
            end else begin
              state   <= DONE;
              mem_req <= 1'b0;
            end
          end
        end
        ACC2: begin
          if (mem_ready) begin
            if (isLoad2) begin
              ReadDataM2 <= mem_rdata;
            end
            state   <= DONE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_pe_mem_sequencer.sv
// Directed testbench for dual_pe_mem_sequencer with a small wait-state
// memory model. Build with MEM_ST_LD_FWD_EN defined to cover forwarding.
module tb_dual_pe_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWriteM1, MemWriteM2, ResultSrcM1, ResultSrcM2;
  logic [31:0] ALU_ResultM1, ALU_ResultM2, WriteDataM1, WriteDataM2;
  logic        StallM;
  logic [31:0] ReadDataM1, ReadDataM2;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  int          waitN = 0;
  logic        readyForce = 1'b0;
  int          waitCnt;
  logic [31:0] memArr [64];
  logic [31:0] addrLog [32];
  logic        weLog [32];
  logic [31:0] wdataLog [32];
  int          logCnt;
  int          reqCount;

  int          nChecks = 0;
  int          nFails = 0;
  int          stalls;
  int          reqCycles;
  int          logBase;
  int          reqBase;

  dual_pe_mem_sequencer #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .MemWriteM1(MemWriteM1), .MemWriteM2(MemWriteM2),
    .ResultSrcM1(ResultSrcM1), .ResultSrcM2(ResultSrcM2),
    .ALU_ResultM1(ALU_ResultM1), .ALU_ResultM2(ALU_ResultM2),
    .WriteDataM1(WriteDataM1), .WriteDataM2(WriteDataM2),
    .StallM(StallM), .ReadDataM1(ReadDataM1), .ReadDataM2(ReadDataM2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: each access completes after waitN low-ready cycles.
  assign mem_ready = readyForce | (mem_req && (waitCnt >= waitN));
  assign mem_rdata = memArr[mem_addr[7:2]];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt <= 0;
      logCnt <= 0;
      reqCount <= 0;
      for (int i = 0; i < 64; i++) memArr[i] <= 32'h0;
      memArr[4] <= 32'hDEADBEEF;
      memArr[9] <= 32'h24240024;
    end else begin
      if (mem_req) reqCount <= reqCount + 1;
      if (mem_req && mem_ready) begin
        waitCnt <= 0;
        if (mem_we) memArr[mem_addr[7:2]] <= mem_wdata;
        if (logCnt < 32) begin
          addrLog[logCnt] <= mem_addr;
          weLog[logCnt] <= mem_we;
          wdataLog[logCnt] <= mem_wdata;
          logCnt <= logCnt + 1;
        end
      end else if (mem_req) begin
        waitCnt <= waitCnt + 1;
      end
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic setInputs(input logic w1, input logic l1, input logic [31:0] a1, input logic [31:0] d1,
                           input logic w2, input logic l2, input logic [31:0] a2, input logic [31:0] d2);
    MemWriteM1 = w1; ResultSrcM1 = l1; ALU_ResultM1 = a1; WriteDataM1 = d1;
    MemWriteM2 = w2; ResultSrcM2 = l2; ALU_ResultM2 = a2; WriteDataM2 = d2;
  endtask

  // Called just after a negedge; returns once the stall drops (DONE cycle).
  task automatic runBundle(input logic w1, input logic l1, input logic [31:0] a1, input logic [31:0] d1,
                           input logic w2, input logic l2, input logic [31:0] a2, input logic [31:0] d2);
    bit done;
    setInputs(w1, l1, a1, d1, w2, l2, a2, d2);
    logBase = logCnt;
    stalls = 0;
    reqCycles = 0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (StallM) begin
        stalls++;
        if (mem_req) reqCycles++;
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    if (!done) checkVal("stall_timeout", 32'd1, 32'd0);
  endtask

  task automatic endBundle();
    setInputs(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    setInputs(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    checkVal("rst_mem_req", 32'(mem_req), 32'd0);
    checkVal("rst_mem_we", 32'(mem_we), 32'd0);
    checkVal("rst_mem_addr", mem_addr, 32'h0);
    checkVal("rst_mem_wdata", mem_wdata, 32'h0);
    checkVal("rst_rd1", ReadDataM1, 32'h0);
    checkVal("rst_rd2", ReadDataM2, 32'h0);
    checkVal("rst_stall", 32'(StallM), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // No-memory bundle, with stray mem_ready that must be ignored
    readyForce = 1'b1;
    reqBase = reqCount;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkVal("nomem_stall", 32'(StallM), 32'd0);
      @(negedge clk);
    end
    readyForce = 1'b0;
    checkVal("nomem_req_count", 32'(reqCount - reqBase), 32'd0);
    checkVal("nomem_rd1", ReadDataM1, 32'h0);

    // PE1 load 0x10, zero-wait
    waitN = 0;
    runBundle(0, 1, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    checkVal("ld1_stalls", 32'(stalls), 32'd2);
    checkVal("ld1_rd1", ReadDataM1, 32'hDEADBEEF);
    checkVal("ld1_rd2", ReadDataM2, 32'h0);
    checkVal("ld1_accesses", 32'(logCnt - logBase), 32'd1);
    endBundle();

    // PE1 store 0x20<-0x11, PE2 load 0x24, 2 wait cycles per access
    waitN = 2;
    runBundle(1, 0, 32'h20, 32'h11, 0, 1, 32'h24, 32'h0);
    checkVal("stld_stalls", 32'(stalls), 32'd7);
    checkVal("stld_no_req_gap", 32'(reqCycles), 32'd6);
    checkVal("stld_accesses", 32'(logCnt - logBase), 32'd2);
    checkVal("stld_addr0", addrLog[logBase], 32'h20);
    checkVal("stld_we0", 32'(weLog[logBase]), 32'd1);
    checkVal("stld_wdata0", wdataLog[logBase], 32'h11);
    checkVal("stld_addr1", addrLog[logBase+1], 32'h24);
    checkVal("stld_we1", 32'(weLog[logBase+1]), 32'd0);
    checkVal("stld_rd2", ReadDataM2, 32'h24240024);
    checkVal("stld_rd1_hold", ReadDataM1, 32'hDEADBEEF);
    endBundle();

    // PE1 store 0x40<-0xCAFE0001, PE2 load 0x40, zero-wait
    waitN = 0;
    runBundle(1, 0, 32'h40, 32'hCAFE0001, 0, 1, 32'h40, 32'h0);
    checkVal("fwd_rd2", ReadDataM2, 32'hCAFE0001);
`ifdef MEM_ST_LD_FWD_EN
    checkVal("fwd_stalls", 32'(stalls), 32'd2);
    checkVal("fwd_accesses", 32'(logCnt - logBase), 32'd1);
`else
    checkVal("fwd_stalls", 32'(stalls), 32'd3);
    checkVal("fwd_accesses", 32'(logCnt - logBase), 32'd2);
`endif
    endBundle();

    // Only PE2 store 0x8<-0x5
    runBundle(0, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h5);
    checkVal("st2_stalls", 32'(stalls), 32'd2);
    checkVal("st2_accesses", 32'(logCnt - logBase), 32'd1);
    checkVal("st2_addr", addrLog[logBase], 32'h8);
    checkVal("st2_we", 32'(weLog[logBase]), 32'd1);
    checkVal("st2_wdata", wdataLog[logBase], 32'h5);
    checkVal("st2_rd2_hold", ReadDataM2, 32'hCAFE0001);
    endBundle();
    #1;
    checkVal("idle_req_low", 32'(mem_req), 32'd0);
    checkVal("idle_addr_hold", mem_addr, 32'h8);
    checkVal("idle_we_hold", 32'(mem_we), 32'd1);

    // Reset during ACC1 with mem_ready held low
    @(negedge clk);
    waitN = 100;
    setInputs(0, 1, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    checkVal("midrst_acc_req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    checkVal("midrst_req", 32'(mem_req), 32'd0);
    checkVal("midrst_we", 32'(mem_we), 32'd0);
    checkVal("midrst_addr", mem_addr, 32'h0);
    checkVal("midrst_wdata", mem_wdata, 32'h0);
    checkVal("midrst_rd1", ReadDataM1, 32'h0);
    checkVal("midrst_rd2", ReadDataM2, 32'h0);
    checkVal("midrst_stall_idle_eq", 32'(StallM), 32'd1);
    @(negedge clk);
    setInputs(0, 0, 0, 0, 0, 0, 0, 0);
    waitN = 0;
    rst = 1'b1;
    @(negedge clk);
    runBundle(0, 1, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    checkVal("postrst_stalls", 32'(stalls), 32'd2);
    checkVal("postrst_rd1", ReadDataM1, 32'hDEADBEEF);
    checkVal("postrst_rd2", ReadDataM2, 32'h0);
    endBundle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/dual_pe_mem_sequencer.md
# dual_pe_mem_sequencer

Sequences the single shared data-memory port between the two processing elements of the dual-issue pipeline during the memory stage. Each cycle it inspects the PE1/PE2 memory-stage bundle and issues any loads and stores to memory one at a time, PE1 (older) first. It freezes both lanes via a common stall until every access in the bundle has completed, then returns the load data to each lane.

## Interface
- `DATA_W`, 32, data width of memory and lanes
- `ADDR_W`, 32, address width (byte address)
- `clk  in  1  rising-edge clock`
- `rst  in  1  asynchronous, active-low reset`
- `MemWriteM1 / MemWriteM2  in  1  lane store request`
- `ResultSrcM1 / ResultSrcM2  in  1  lane load request (1 = load)`
- `ALU_ResultM1 / ALU_ResultM2  in  ADDR_W  lane byte address`
- `WriteDataM1 / WriteDataM2  in  DATA_W  lane store data`
- `StallM  out  1  freeze both lanes' M-stage registers (combinational)`
- `ReadDataM1 / ReadDataM2  out  DATA_W  registered load data, valid when StallM=0 in DONE`
- `mem_req  out  1  access request (registered)`
- `mem_we  out  1  1 = write (registered)`
- `mem_addr  out  ADDR_W  access address (registered)`
- `mem_wdata  out  DATA_W  write data (registered)`
- `mem_rdata  in  DATA_W  read data, valid with mem_ready`
- `mem_ready  in  1  completes the current access when sampled high with mem_req`

## Operation
- Lane needs memory: `needN = MemWriteMN | ResultSrcMN`. Both set together is illegal and treated as a store.
- Upstream holds all lane inputs stable while `StallM=1`.
- States and transitions:
  - IDLE:
    - need1 -> ACC1, loading PE1 onto the mem_* registers.
    - else need2 -> ACC2, loading PE2 onto the mem_* registers.
    - else stay in IDLE.
  - ACC1: on mem_ready:
    - Capture mem_rdata into ReadDataM1 if PE1 is a load.
    - need2 -> ACC2, reloading the mem_* registers with PE2; mem_req stays high.
    - else -> DONE.
  - ACC2: on mem_ready, capture into ReadDataM2 if PE2 is a load, then -> DONE.
  - DONE: mem_req=0. StallM=0, so the bundle advances at the end of this cycle. Next state is IDLE.
- StallM = (IDLE & (need1|need2)) | ACC1 | ACC2.
- A bundle with no memory operation passes through IDLE with StallM=0 and no overhead.
- ReadDataMx holds its last captured value until overwritten; lanes that are stores or idle leave it unchanged.
- mem_req low in IDLE and DONE; mem_we/addr/wdata hold their last values when mem_req=0.

## Timing
- Reset (async assert, sync release): state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; ReadDataM1=ReadDataM2=0.
- StallM in reset follows the IDLE equation.
- Each access waits one cycle plus N wait cycles, where N is the number of mem_ready-low cycles.
- A single-op bundle with zero-wait memory stalls 2 cycles (IDLE, ACC1); the DONE cycle advances it.
- A two-op bundle with zero-wait memory stalls 3 cycles.
- Back-to-back accesses: the PE2 request follows the PE1 completion in the very next cycle with no mem_req gap.
- mem_ready while mem_req=0 is ignored.
- Reset asserted mid-access returns to IDLE immediately; the outstanding access is abandoned and the memory model must tolerate this.

## Configuration
- `MEM_ST_LD_FWD_EN` defined:
  - Applies when PE1 is a store, PE2 is a load, and `ALU_ResultM1[ADDR_W-1:2] == ALU_ResultM2[ADDR_W-1:2]`.
  - On ACC1 completion, `ReadDataM2 <= WriteDataM1` and the FSM goes directly to DONE; no PE2 memory access is made.
  - This saves one access.
- Undefined: PE2 always performs its own access after PE1, and the memory returns the stored value.

## Test plan
- No-mem bundle (all Mem/ResultSrc=0) -> StallM=0 every cycle, mem_req never asserted.
- PE1 load addr 0x10, mem_rdata=0xDEADBEEF, zero-wait -> StallM=1 for 2 cycles; ReadDataM1=0xDEADBEEF in the DONE cycle; ReadDataM2 unchanged.
- PE1 store 0x20←0x11, PE2 load 0x24, mem_ready low 2 cycles per access -> mem_addr sequence 0x20 then 0x24; StallM=1 for 7 cycles; ReadDataM2=mem_rdata.
- PE1 store 0x40←0xCAFE0001, PE2 load 0x40:
  - Fwd on: one access, ReadDataM2=0xCAFE0001, stall 2 cycles.
  - Fwd off: two accesses, stall 3 cycles.
- Only PE2 store 0x8←0x5 -> FSM goes IDLE->ACC2->DONE, mem_we=1, mem_addr=0x8, mem_wdata=0x5.
- rst low during ACC1 with mem_ready held low -> mem_req=0 and all outputs 0 immediately; after release a new PE1 load completes normally.
